// File: rtl/state_digest_streamer.sv
// rtl/state_digest_streamer.sv - snapshot capture, per-word stream and rotate-XOR frame signature
// Define DIGEST_SIG_BEAT_EN to append the signature as an extra final beat of each frame.
module state_digest_streamer #(
  parameter int                WIDTH  = 32,
  parameter int                NWORDS = 8,
  parameter int                ROT    = 5,
  parameter logic [WIDTH-1:0]  SEED   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_valid,
  input  logic [NWORDS*WIDTH-1:0]  cap_data,
  output logic                     cap_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic [WIDTH-1:0]         sig,
  output logic [15:0]              frame_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int IW = $clog2(NWORDS + 1);
  localparam int SW = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);
`ifndef DIGEST_SIG_BEAT_EN
  localparam logic [IW-1:0] PEN_IDX  = IW'(NWORDS - 2);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_SIGB = 2'd2
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_idx;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_buf [NWORDS];
  logic              r_out_valid;
  logic              r_out_last;
  logic [WIDTH-1:0]  r_out_data;
  logic [WIDTH-1:0]  r_sig;
  logic [15:0]       r_frame_cnt;
  logic [15:0]       r_drop_cnt;

  logic              w_cap_ready;
  logic              w_hs;
  logic [SW-1:0]     w_sel;
  logic [SW-1:0]     w_sel_nxt;
  logic [WIDTH-1:0]  w_acc_next;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x);
    return (x << ROT) | (x >> (WIDTH - ROT));
  endfunction

  assign w_cap_ready = (r_state == S_IDLE);
  assign w_hs        = r_out_valid & out_ready;
  assign w_sel       = r_idx[SW-1:0];
  assign w_sel_nxt   = w_sel + 1'b1;
  assign w_acc_next  = rotl(r_acc) ^ r_buf[w_sel];

  // The buffer is only written from IDLE, so refused snapshots never disturb a frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) r_buf[i] <= '0;
    end else if (w_cap_ready && cap_valid) begin
      for (int i = 0; i < NWORDS; i++) r_buf[i] <= cap_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (cap_valid && !w_cap_ready && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_sig       <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cap_valid) begin
            r_idx       <= '0;
            r_acc       <= SEED;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_out_data  <= cap_data[WIDTH-1:0];
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_hs) begin
            r_acc <= w_acc_next;
            if (r_idx == LAST_IDX) begin
`ifdef DIGEST_SIG_BEAT_EN
              r_idx      <= r_idx + 1'b1;
              r_out_data <= w_acc_next;
              r_out_last <= 1'b1;
              r_state    <= S_SIGB;
`else
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_data  <= '0;
              r_sig       <= w_acc_next;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_state     <= S_IDLE;
`endif
            end else begin
              // Next word is preloaded here so out_data/out_last are plain registers.
              r_idx      <= r_idx + 1'b1;
              r_out_data <= r_buf[w_sel_nxt];
`ifdef DIGEST_SIG_BEAT_EN
              r_out_last <= 1'b0;
`else
              r_out_last <= (r_idx == PEN_IDX);
`endif
            end
          end
        end
`ifdef DIGEST_SIG_BEAT_EN
        S_SIGB: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_sig       <= r_acc;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= S_IDLE;
          end
        end
`endif
        default: begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cap_ready = w_cap_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;
  assign sig       = r_sig;
  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: doc/state_digest_streamer.md
Name: state_digest_streamer

Overview:
- Downstream consumer of the eight-register 32-bit mixing core.
- Captures a snapshot of all state words on a strobe and serialises them over a valid/ready stream, one word per beat.
- Computes a per-frame rotate-XOR signature so benches and host logic can check core output cheaply.
- Counts captured frames, and counts snapshots dropped while a frame is still draining.

Parameters:
- WIDTH, 32, bits per state word
- NWORDS, 8, words per snapshot (≥2)
- ROT, 5, left-rotate amount for the signature (0 < ROT < WIDTH)
- SEED, 0, initial signature value at the start of each frame

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- cap_valid  in  1  snapshot strobe from the core, asserted every cycle a new state is available
- cap_data  in  NWORDS*WIDTH  snapshot; word i = cap_data[i*WIDTH +: WIDTH]
- cap_ready  out  1  high only when a snapshot will be accepted this cycle
- out_valid  out  1  stream beat valid
- out_ready  in  1  downstream accept
- out_data  out  WIDTH  beat payload
- out_last  out  1  final beat of the frame
- sig  out  WIDTH  signature of the last completed frame
- frame_cnt  out  16  frames fully sent; wraps modulo 2^16
- drop_cnt  out  16  snapshots refused; saturates at 0xFFFF

Behaviour:
- Reset (async, any time, including mid-frame):
  - state = IDLE; the frame in flight is aborted and no partial last is emitted.
  - out_valid = 0, out_last = 0, out_data = 0, sig = 0, frame_cnt = 0, drop_cnt = 0, cap_ready = 1.
- States are IDLE, SEND, SIGB.
- IDLE:
  - cap_ready = 1 (combinational on state), out_valid = 0.
  - When cap_valid = 1: latch cap_data into the word buffer, set idx = 0, set acc = SEED, go to SEND.
- SEND:
  - out_valid = 1, out_data = buf[idx].
  - out_last = 1 only if idx == NWORDS-1 and the signature beat is compiled out.
  - On handshake (out_valid & out_ready): acc <= rotl(acc, ROT) ^ buf[idx]; idx++.
  - After the handshake at idx == NWORDS-1: go to SIGB if the signature beat is enabled; otherwise go to IDLE, with sig <= final acc and frame_cnt++.
- SIGB:
  - out_valid = 1, out_data = acc, out_last = 1.
  - On handshake: sig <= acc, frame_cnt++, go to IDLE.
- Stream rules:
  - While out_valid = 1 and out_ready = 0, out_data and out_last hold stable.
  - out_valid never drops without a handshake.
- Latency:
  - The capture cycle puts word 0 on out_valid the next cycle.
  - With out_ready held at 1, a frame takes NWORDS (+1) consecutive beats.
  - IDLE is re-entered the cycle after the last beat, so the next capture can happen at the earliest one cycle after that.
- Drops:
  - Any cycle with cap_valid = 1 and cap_ready = 0 increments drop_cnt, saturating at 0xFFFF.
  - A dropped snapshot never alters the buffer.
- Arithmetic:
  - All arithmetic is modulo 2^WIDTH.
  - rotl(x, r) = (x << r) | (x >> (WIDTH-r)).
- idx is $clog2(NWORDS+1) bits wide and never exceeds NWORDS-1 in SEND.

Optional Feature:
- Macro: DIGEST_SIG_BEAT_EN.
- Defined: frame is NWORDS+1 beats; the signature beat is the last beat and carries out_last.
- Undefined: SIGB is removed; the frame is NWORDS beats with out_last on word NWORDS-1; sig is still updated at frame end.

Test Plan:
- Reset then idle, cap_valid = 0 for 10 cycles -> out_valid = 0, cap_ready = 1, sig = 0, both counters 0.
- SEED = 0, ROT = 5, macro defined, snapshot words 0..7 = 0,1,…,7, out_ready = 1:
  - Beats 0..7 output 0..7, then beat 8 = 0x443214C7 with out_last = 1.
  - sig = 0x443214C7 and frame_cnt = 1 on the cycle after beat 8.
- Same snapshot with out_ready toggling 1,0,1,0 -> identical beat sequence; out_data is stable across every stalled cycle.
- cap_valid held high for 30 cycles, out_ready = 1, macro defined:
  - Captures occur on cycles 0, 10 and 20; cycles 1–9, 11–19 and 21–29 are refused (27 drops).
  - frame_cnt = 3 once the third frame completes, with drop_cnt = 27.
- rst asserted during beat 3 of a frame -> out_valid = 0 immediately (async); no out_last; frame_cnt unchanged from 0; cap_ready = 1 after rst release.
- Macro undefined, same 0..7 snapshot -> 8 beats, out_last on the beat carrying 7, sig = 0x443214C7.
